// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus external memory bus for the port arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until ack; memory stalls through ACK_n.
interface mem_port_arbiter_if #(
  parameter int BIT_WIDTH = 32
);
  // instruction fetch requester
  logic                 i_req;
  logic [BIT_WIDTH-1:0] i_addr;
  logic                 i_ack;
  logic [BIT_WIDTH-1:0] i_rdata;
  // data requester
  logic                 d_req;
  logic                 d_write;
  logic [1:0]           d_size;
  logic [BIT_WIDTH-1:0] d_addr;
  logic [BIT_WIDTH-1:0] d_wdata;
  logic                 d_ack;
  logic [BIT_WIDTH-1:0] d_rdata;
  logic                 err;
  // external memory bus
  logic [BIT_WIDTH-1:0] MAD;
  logic                 MREQ;
  logic                 WRITE;
  logic [1:0]           SIZE;
  logic                 IFETCH;
  logic [BIT_WIDTH-1:0] MDT_O;
  logic [BIT_WIDTH-1:0] MDT_I;
  logic                 ACK_n;
  logic                 bus_err;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, MDT_I, ACK_n,
    output i_ack, i_rdata, d_ack, d_rdata, err, MAD, MREQ, WRITE, SIZE, IFETCH, MDT_O, bus_err
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, MDT_I, ACK_n,
    input  i_ack, i_rdata, d_ack, d_rdata, err, MAD, MREQ, WRITE, SIZE, IFETCH, MDT_O, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data requesters, data first with a starvation guard.
// Latency: grant cycle, >=1 bus cycle, registered ack cycle (3 cycles with a 1-cycle memory).
// Backpressure: requesters hold req until ack; memory stalls via ACK_n, aborted with err after TIMEOUT busy cycles.
module mem_port_arbiter #(
  parameter int BIT_WIDTH   = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [3:0]           streak;
  logic [7:0]           tcnt;
  logic                 grant_d, grant_i, ack_ok, tmo;
  logic [BIT_WIDTH-1:0] lat_addr, lat_wdata;
  logic [1:0]           lat_size;
  logic                 lat_write, lat_ifetch;

  // Grant selection in IDLE and completion/abort detection in BUSY.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      // data wins unless it has already taken MAX_DSTREAK grants past a waiting fetch
      if (bus.d_req && !(bus.i_req && streak == STREAK_MAX)) grant_d = 1'b1;
      else if (bus.i_req)                                    grant_i = 1'b1;
    end
    ack_ok = (state == BUSY) && !bus.ACK_n;
    tmo    = (state == BUSY) && bus.ACK_n && (tcnt == TMO_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d || grant_i) state_nxt = BUSY;
      BUSY:    if (ack_ok || tmo)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs: strobes only while BUSY, address/size/data hold their latched values.
  always_comb begin
    bus.MREQ   = (state == BUSY);
    bus.WRITE  = (state == BUSY) && lat_write;
    bus.IFETCH = (state == BUSY) && lat_ifetch;
    bus.MAD    = lat_addr;
    bus.SIZE   = lat_size;
    bus.MDT_O  = lat_wdata;
  end

  // Latch request fields at grant and track the data streak and busy-cycle count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= 2'b00;
      lat_write  <= 1'b0;
      lat_ifetch <= 1'b0;
      streak     <= 4'd0;
      tcnt       <= 8'd0;
    end else if (grant_d) begin
      lat_addr   <= bus.d_addr;
      lat_wdata  <= bus.d_wdata;
      lat_size   <= bus.d_size;
      lat_write  <= bus.d_write;
      lat_ifetch <= 1'b0;
      tcnt       <= 8'd0;
      if (!bus.i_req)                streak <= 4'd0;
      else if (streak != STREAK_MAX) streak <= streak + 4'd1;
    end else if (grant_i) begin
      lat_addr   <= bus.i_addr;
      lat_wdata  <= '0;
      lat_size   <= 2'b00;
      lat_write  <= 1'b0;
      lat_ifetch <= 1'b1;
      tcnt       <= 8'd0;
      streak     <= 4'd0;
    end else if (state == BUSY && bus.ACK_n && !tmo) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  // Completion: one-cycle ack pulse, read-data capture, abort reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.i_ack   <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.err     <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
      bus.bus_err <= 1'b0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.err   <= 1'b0;
      if (ack_ok || tmo) begin
        bus.err <= tmo;
        if (tmo) bus.bus_err <= 1'b1;
        if (lat_ifetch) begin
          bus.i_ack   <= 1'b1;
          bus.i_rdata <= tmo ? '0 : bus.MDT_I;
        end else begin
          bus.d_ack <= 1'b1;
          // a completed store leaves the last load result in place
          if (tmo)             bus.d_rdata <= '0;
          else if (!lat_write) bus.d_rdata <= bus.MDT_I;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard of expected bus phases and acks.
// Latency: checks request-to-ack cycle counts for normal, stalled and aborted transactions.
// Backpressure: memory model stalls or hangs ACK_n on demand.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;

  mem_port_arbiter_if #(.BIT_WIDTH(32)) bus ();

  mem_port_arbiter #(.BIT_WIDTH(32), .MAX_DSTREAK(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_i;
    logic [31:0] addr;
    bit          write;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // memory model controls
  bit mem_hang  = 1'b0;
  bit ack_force = 1'b0;
  int mem_lat   = 1;
  int bus_cyc   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_d(input logic [31:0] a, input bit w, input logic [1:0] s,
                                input logic [31:0] wd, input logic [31:0] rd, input bit e);
    exp_t x;
    x.is_i = 1'b0; x.addr = a; x.write = w; x.size = s; x.wdata = wd; x.rdata = rd; x.err = e;
    return x;
  endfunction

  function automatic exp_t mk_i(input logic [31:0] a, input logic [31:0] rd, input bit e);
    exp_t x;
    x.is_i = 1'b1; x.addr = a; x.write = 1'b0; x.size = 2'b00; x.wdata = 32'h0; x.rdata = rd; x.err = e;
    return x;
  endfunction

  // Memory model: acks on the mem_lat-th bus cycle unless hung; ack_force drives ACK_n low regardless.
  always @(negedge clk) begin
    if (bus.MREQ) bus_cyc++;
    else          bus_cyc = 0;
    if (ack_force) begin
      bus.ACK_n = 1'b0;
    end else if (bus.MREQ && !mem_hang && bus_cyc >= mem_lat) begin
      bus.ACK_n = 1'b0;
      bus.MDT_I = mem_word(bus.MAD);
    end else begin
      bus.ACK_n = 1'b1;
      bus.MDT_I = 32'h0BAD_0BAD;
    end
  end

  // Monitor: every bus cycle must match the head transaction; every ack pops and checks it.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.MREQ) begin
        if (exp_q.size() == 0) begin
          chk("bus_unexpected", 1'b1, 1'b0);
        end else begin
          chk("bus_mad", bus.MAD, exp_q[0].addr);
          chk("bus_write_size_ifetch", {bus.WRITE, bus.SIZE, bus.IFETCH},
              {exp_q[0].write, exp_q[0].size, exp_q[0].is_i});
          chk("bus_mdt_o", bus.MDT_O, exp_q[0].wdata);
        end
      end
      if (bus.i_ack || bus.d_ack) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", {bus.i_ack, bus.d_ack}, 2'b00);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_kind", {bus.i_ack, bus.d_ack}, e.is_i ? 2'b10 : 2'b01);
          chk("ack_rdata", e.is_i ? bus.i_rdata : bus.d_rdata, e.rdata);
          chk("ack_err", bus.err, e.err);
        end
      end else if (bus.err) begin
        chk("err_without_ack", bus.err, 1'b0);
      end
    end
  end

  // Wait for the requester's ack, dropping its req in the ack cycle; counts negedges waited.
  task automatic wait_ack(input bit is_i, output int cyc);
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc++;
      if (is_i ? bus.i_ack : bus.d_ack) begin
        if (is_i) bus.i_req = 1'b0;
        else      bus.d_req = 1'b0;
        return;
      end
    end
    chk("ack_wait_expired", 1'b0, 1'b1);
    cyc = -1;
  endtask

  initial begin
    int cyc;
    int acks;
    rst         = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_write = 1'b0;
    bus.d_size  = 2'b00;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;

    // reset state
    @(negedge clk);
    chk("rst_strobes", {bus.MREQ, bus.WRITE, bus.IFETCH, bus.i_ack, bus.d_ack, bus.err, bus.bus_err}, 7'b0);
    chk("rst_mad", bus.MAD, 32'h0);
    chk("rst_size", bus.SIZE, 2'b00);
    chk("rst_mdt_o", bus.MDT_O, 32'h0);
    chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single word load: request cycle, bus cycle, ack cycle
    exp_q.push_back(mk_d(32'h100, 1'b0, 2'b00, 32'h0, 32'hDEAD_BEEF, 1'b0));
    bus.d_addr = 32'h100; bus.d_size = 2'b00; bus.d_write = 1'b0; bus.d_req = 1'b1;
    wait_ack(1'b0, cyc);
    chk("load_latency", cyc, 2);
    chk("load_gap_mreq", bus.MREQ, 1'b0);

    // ACK_n low while idle must not produce an ack
    ack_force = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_ack_ignored", {bus.i_ack, bus.d_ack, bus.MREQ}, 3'b000);
    end
    ack_force = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // both requesters held: D,D,D,D,I,D,D,D,D,I
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(mk_d(32'h2000, 1'b0, 2'b00, 32'h0, 32'h5A5A_2000, 1'b0));
      exp_q.push_back(mk_i(32'h1000, 32'h5A5A_1000, 1'b0));
    end
    bus.i_addr = 32'h1000; bus.d_addr = 32'h2000;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 300 && acks < 10; c++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) acks++;
      if (acks == 10) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end
    end
    chk("prio_ack_count", acks, 10);
    @(negedge clk);

    // byte store: d_rdata keeps the previous load result
    exp_q.push_back(mk_d(32'hF000_0000, 1'b1, 2'b10, 32'h41, 32'h5A5A_2000, 1'b0));
    bus.d_addr = 32'hF000_0000; bus.d_wdata = 32'h41; bus.d_size = 2'b10; bus.d_write = 1'b1;
    bus.d_req = 1'b1;
    wait_ack(1'b0, cyc);
    chk("store_latency", cyc, 2);
    bus.d_write = 1'b0; bus.d_size = 2'b00; bus.d_wdata = 32'h0;
    @(negedge clk);

    // address change after grant is ignored; 3-cycle memory
    mem_lat = 3;
    exp_q.push_back(mk_d(32'h200, 1'b0, 2'b00, 32'h0, 32'h5A5A_0200, 1'b0));
    bus.d_addr = 32'h200; bus.d_req = 1'b1;
    @(negedge clk);
    bus.d_addr = 32'h300;
    wait_ack(1'b0, cyc);
    chk("stall_latency", cyc, 3);
    mem_lat = 1;
    @(negedge clk);

    // fetch timeout: abort after 16 busy cycles
    chk("bus_err_before_tmo", bus.bus_err, 1'b0);
    mem_hang = 1'b1;
    exp_q.push_back(mk_i(32'h4000, 32'h0, 1'b1));
    bus.i_addr = 32'h4000; bus.i_req = 1'b1;
    wait_ack(1'b1, cyc);
    chk("tmo_latency", cyc, 17);
    chk("tmo_bus_err_set", bus.bus_err, 1'b1);
    mem_hang = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("tmo_bus_err_sticky", {bus.bus_err, bus.err}, 2'b10);

    // asynchronous reset mid-transaction, then a fresh transaction after release
    mem_hang = 1'b1;
    exp_q.push_back(mk_d(32'h500, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0));
    bus.d_addr = 32'h500; bus.d_req = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("pre_rst_busy", bus.MREQ, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_strobes", {bus.MREQ, bus.WRITE, bus.IFETCH, bus.d_ack, bus.err, bus.bus_err}, 6'b0);
    chk("arst_mad", bus.MAD, 32'h0);
    exp_q.delete();
    @(negedge clk);
    chk("arst_no_ack", {bus.d_ack, bus.MREQ}, 2'b00);
    @(negedge clk);
    mem_hang = 1'b0;
    exp_q.push_back(mk_d(32'h500, 1'b0, 2'b00, 32'h0, 32'h5A5A_0500, 1'b0));
    rst = 1'b1;
    wait_ack(1'b0, cyc);
    chk("post_rst_latency", cyc, 2);
    chk("post_rst_bus_err", bus.bus_err, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the top-level core.
- Fixed data-over-instruction priority, with a starvation guard that forces an instruction grant after a run of data grants.
- Per-transaction timeout with a sticky bus error.
- Drives MREQ/WRITE/SIZE/address and samples the active-low acknowledge ACK_n from the memory model.

Parameters:
- BIT_WIDTH, 32: address/data width.
- MAX_DSTREAK, 4: consecutive data grants allowed while i_req is pending (1..15).
- TIMEOUT, 16: BUSY cycles without acknowledge before abort (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  32  fetch address.
- i_ack  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  32  fetched word.
- d_req  in  1  data request; held until d_ack.
- d_write  in  1  1 = store, 0 = load.
- d_size  in  2  00 word, 01 half, 1x byte (bus encoding).
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle pulse; d_rdata valid on loads.
- d_rdata  out  32  load data.
- err  out  1  one-cycle pulse accompanying i_ack/d_ack on a timeout abort.
- MAD  out  32  memory address.
- MREQ  out  1  memory request.
- WRITE  out  1  write strobe qualifier.
- SIZE  out  2  access size.
- IFETCH  out  1  1 = current transaction is an instruction fetch.
- MDT_O  out  32  write data.
- MDT_I  in  32  read data.
- ACK_n  in  1  active-low acknowledge, sampled on rising edge.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; state IDLE; streak counter 0; timeout counter 0; bus_err 0.
- States: IDLE, BUSY.
- IDLE → BUSY when any request is present. Grant selection:
  - d_req and not i_req: data.
  - i_req and not d_req: instruction.
  - both present: data, unless streak == MAX_DSTREAK, then instruction.
- On grant (registered), the next cycle drives:
  - MREQ=1.
  - MAD = granted address.
  - Data grant: WRITE=d_write, SIZE=d_size, MDT_O=d_wdata, IFETCH=0.
  - Instruction grant: WRITE=0, SIZE=00, MDT_O=0, IFETCH=1.
  - Request fields are latched at grant; later changes are ignored until completion.
- Streak counter:
  - +1 on each data grant while i_req is high, saturating at MAX_DSTREAK.
  - Cleared on any instruction grant, and on a data grant with i_req low.
- BUSY, ACK_n sampled 0:
  - Capture MDT_I into i_rdata (fetch) or d_rdata (load; store leaves d_rdata unchanged).
  - Pulse the matching i_ack/d_ack for exactly one cycle.
  - Deassert MREQ/WRITE/IFETCH (MAD/SIZE may hold); return to IDLE.
  - The minimum gap between transactions is one cycle with MREQ=0.
- BUSY, ACK_n=1: timeout counter increments. When it reaches TIMEOUT:
  - Abort the transaction.
  - Pulse the matching ack together with err; rdata = 0.
  - Set bus_err (held until reset); return to IDLE.
- Timeout counter clears on every grant.
- ACK_n=0 in IDLE is ignored; it never produces an ack.
- A requester dropping req mid-transaction does not cancel it; the ack still pulses.
- A requester must not re-raise req in the same cycle as its ack. A req seen high in IDLE is treated as a new request.
- Reset mid-transaction: immediate return to IDLE with outputs 0; no ack is produced.
- Latency from request to ack, with a 1-cycle memory: 3 cycles (grant, bus, ack).

Test Plan:
- Single load: d_req with d_addr=0x100, d_size=00, MDT_I=0xDEADBEEF, ACK_n low on the first bus cycle → MREQ=1, WRITE=0, MAD=0x100 for 1 cycle; d_ack pulses with d_rdata=0xDEADBEEF; one idle cycle follows.
- Priority/starvation: i_req and d_req held high continuously, MAX_DSTREAK=4 → grant order D,D,D,D,I,D,D,D,D,I; IFETCH=1 only on the I transactions.
- Store of a byte to 0xF0000000 with d_wdata=0x41, d_size=10 → MREQ=1, WRITE=1, SIZE=10, MDT_O=0x41; d_ack pulses; d_rdata unchanged.
- Timeout: i_req with ACK_n never asserted, TIMEOUT=16 → i_ack and err pulse together after 16 BUSY cycles; i_rdata=0; bus_err=1 until reset.
- Asynchronous reset asserted during BUSY with d_req pending → all outputs 0 immediately, no d_ack; after rst=1 with d_req still high, a fresh transaction completes normally.
- Request field change after grant: d_addr changes 0x200→0x300 during BUSY → MAD stays 0x200 until the ack.
